// File: rtl/arm_fetch_pkg.sv
// Shared fetch-stage constants and state encoding for the PC control front end.
package arm_fetch_pkg;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_ctrl_chk.sv
// Simulation checks on the fetch credit/drop bookkeeping.
module fetch_pc_ctrl_chk #(
  parameter int QDEPTH = 2,
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input logic          clk,
  input logic          Reset,
  input logic [CW-1:0] inflight,
  input logic [CW-1:0] drop,
  input logic [CW-1:0] occ,
  input logic [CW-1:0] side_cnt,
  input logic          side_full,
  input logic          side_empty,
  input logic          side_push,
  input logic          side_pop,
  input logic          outq_full,
  input logic          outq_push,
  input logic          outq_pop
);
  localparam logic [CW:0] QDEPTH_C = (CW+1)'(QDEPTH);

  a_inflight_max: assert property (@(posedge clk) disable iff (Reset) {1'b0, inflight} <= QDEPTH_C);
  a_drop_max:     assert property (@(posedge clk) disable iff (Reset) {1'b0, drop} <= QDEPTH_C);
  a_credit_sum:   assert property (@(posedge clk) disable iff (Reset)
                                   ({1'b0, inflight} + {1'b0, occ}) <= QDEPTH_C);
  a_side_match:   assert property (@(posedge clk) disable iff (Reset) side_cnt == inflight);
  a_side_ovf:     assert property (@(posedge clk) disable iff (Reset) !(side_push && side_full));
  a_side_unf:     assert property (@(posedge clk) disable iff (Reset) !(side_pop && side_empty));
  a_outq_ovf:     assert property (@(posedge clk) disable iff (Reset) !(outq_push && outq_full && !outq_pop));
endmodule

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // pointer and occupancy tracking; a pop in the same cycle as a push to a full queue frees the slot
  always_ff @(posedge clk) begin
    if (Reset || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // payload storage, qualified by valid state so it needs no reset
  always_ff @(posedge clk) begin
    if (push && !flush && !Reset) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch front end: next-PC selection, credit-limited in-order IMEM requests,
// response buffering for IF/ID and wrong-path response discard after a redirect.
module fetch_pc_ctrl
  import arm_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic [ADDR_W-1:0]  pc_d,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0]   QDEPTH_C = (CW+1)'(QDEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};

  fetch_state_e state_r, state_s;
  logic [CW-1:0] inflight_r, inflight_s, drop_r, drop_s;
  logic [CW-1:0] occ_s, side_cnt_s;
  logic [CW:0]   used_s;
  logic          side_full_s, side_empty_s, outq_full_s, outq_empty_s;
  logic [ADDR_W-1:0]         side_head_s;
  logic [ADDR_W+INSTR_W-1:0] outq_head_s;
  logic [ADDR_W-1:0]         pc_s;
  logic if_valid_s, pop_s, req_valid_s, issue_s, rsp_keep_s, rsp_drop_s;

  // handshakes; the slot freed by this cycle's pop already counts as a credit so decode can run at 1/clk
  always_comb begin
    if_valid_s  = !Reset && !outq_empty_s && !redirect_valid;
    pop_s       = if_valid_s && if_ready;
    used_s      = {1'b0, inflight_r} + {1'b0, occ_s} - {{CW{1'b0}}, pop_s};
    req_valid_s = !Reset && (used_s < QDEPTH_C) && !redirect_valid;
    issue_s     = req_valid_s && imem_req_ready;
    rsp_drop_s  = imem_rsp_valid && (redirect_valid || (state_r == DRAIN));
    rsp_keep_s  = imem_rsp_valid && !rsp_drop_s;
  end

  // counter and RUN/DRAIN next state; a redirect moves every in-flight request into the drop count
  always_comb begin
    inflight_s = inflight_r;
    drop_s     = drop_r;
    state_s    = state_r;
    if (redirect_valid) begin
      inflight_s = ZERO_C;
      drop_s     = drop_r + inflight_r - (imem_rsp_valid ? ONE_C : ZERO_C);
    end else begin
      inflight_s = inflight_r + (issue_s ? ONE_C : ZERO_C) - (rsp_keep_s ? ONE_C : ZERO_C);
      drop_s     = drop_r - (rsp_drop_s ? ONE_C : ZERO_C);
    end
    case (state_r)
      RUN:     state_s = (drop_s != ZERO_C) ? DRAIN : RUN;
      DRAIN:   state_s = (drop_s == ZERO_C) ? RUN : DRAIN;
      default: state_s = RUN;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r    <= RUN;
      inflight_r <= ZERO_C;
      drop_r     <= ZERO_C;
    end else begin
      state_r    <= state_s;
      inflight_r <= inflight_s;
      drop_r     <= drop_s;
    end
  end

  // next-PC mux, redirect has priority over sequential advance
  always_comb begin
    if (Reset) begin
      pc_s = {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      pc_s = redirect_target;
    end else if (issue_s) begin
      pc_s = pc_q + PC_INC;
    end else begin
      pc_s = pc_q;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .W(ADDR_W)) u_side_q (
    .clk(clk), .Reset(Reset), .flush(redirect_valid),
    .push(issue_s), .push_data(pc_q), .pop(rsp_keep_s),
    .head(side_head_s), .full(side_full_s), .empty(side_empty_s), .count(side_cnt_s)
  );

  fetch_queue #(.DEPTH(QDEPTH), .W(ADDR_W + INSTR_W)) u_out_q (
    .clk(clk), .Reset(Reset), .flush(redirect_valid),
    .push(rsp_keep_s), .push_data({side_head_s, imem_rsp_data}), .pop(pop_s),
    .head(outq_head_s), .full(outq_full_s), .empty(outq_empty_s), .count(occ_s)
  );

  fetch_pc_ctrl_chk #(.QDEPTH(QDEPTH)) u_chk (
    .clk(clk), .Reset(Reset), .inflight(inflight_r), .drop(drop_r), .occ(occ_s),
    .side_cnt(side_cnt_s), .side_full(side_full_s), .side_empty(side_empty_s),
    .side_push(issue_s), .side_pop(rsp_keep_s),
    .outq_full(outq_full_s), .outq_push(rsp_keep_s), .outq_pop(pop_s)
  );

  assign pc_d           = pc_s;
  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_s;
  assign if_pc          = outq_head_s[ADDR_W+INSTR_W-1:INSTR_W];
  assign if_instr       = outq_head_s[INSTR_W-1:0];
endmodule
